// File: rtl/mo_mul_pkg.sv
// Shared helpers for the pipelined Montgomery multiplier.
//   mo_q         : modulus Q = Q_K * 2^Q_M + 1
//   mo_lat       : registered latency (capture + W/RADIX_BITS iterations + correction)
//   mo_params_ok : legality of a parameter set, used for elaboration-time checking
package mo_mul_pkg;

  function automatic int unsigned mo_q(input int unsigned q_k, input int unsigned q_m);
    return q_k * (32'd1 << q_m) + 32'd1;
  endfunction

  function automatic int unsigned mo_lat(input int unsigned w, input int unsigned radix_bits);
    return w / radix_bits + 32'd2;
  endfunction

  function automatic bit mo_params_ok(input int unsigned q_m, input int unsigned q_k,
                                      input int unsigned w, input int unsigned radix_bits);
    longint unsigned q;
    q = longint'(mo_q(q_k, q_m));
    return (radix_bits == 1 || radix_bits == 2) && (w % radix_bits == 0) &&
           (q_m >= radix_bits) && (q < (64'd1 << w));
  endfunction

endpackage

// File: rtl/mo_mul_iter.sv
// One radix-2^RADIX_BITS Montgomery iteration for a single lane, purely combinational.
//   s_i      : running partial result S (S < 2Q)
//   a_i      : multiplicand a
//   d_i      : current digit of b
//   s_next_o : (S + d*a + m*Q) / 2^RADIX_BITS with m chosen to make the division exact
module mo_mul_iter #(
  parameter int unsigned W          = 12,
  parameter int unsigned RADIX_BITS = 1,
  parameter int unsigned Q          = 3329
) (
  input  logic [W:0]            s_i,
  input  logic [W-1:0]          a_i,
  input  logic [RADIX_BITS-1:0] d_i,
  output logic [W:0]            s_next_o
);

  // Wide enough for S + d*a + m*Q < 2^(RADIX_BITS+1) * Q.
  localparam int unsigned TW = W + RADIX_BITS + 1;

  logic [TW-1:0]         t;
  logic [TW-1:0]         mq;
  logic [TW-1:0]         sum;
  logic [RADIX_BITS-1:0] m;

  always_comb begin
    t        = TW'(s_i) + TW'(d_i) * TW'(a_i);
    // Q is 1 mod 2^RADIX_BITS, so -Q^-1 mod 2^RADIX_BITS is -1 and m is just -T.
    m        = -t[RADIX_BITS-1:0];
    mq       = TW'(m) * TW'(Q);
    sum      = t + mq;
    s_next_o = (W+1)'(sum >> RADIX_BITS);
  end

endmodule

// File: rtl/mo_mul_pipe.sv
// Fully pipelined multi-lane Montgomery multiplier: out = a*b*2^-W mod Q, in 0..Q-1.
//   clk, rst             : clock and synchronous active-high reset
//   in_valid/in_ready    : operand handshake; in_ready depends only on out_valid/out_ready
//   in_a, in_b           : per-lane operands, lane i at [i*W +: W], each < Q
//   in_tag               : sideband returned with the result
//   out_valid/out_ready  : result handshake; a stalled output freezes the whole pipe
//   out_result, out_tag  : per-lane results and the matching tag
module mo_mul_pipe
  import mo_mul_pkg::*;
#(
  parameter int unsigned Q_M        = 8,
  parameter int unsigned Q_K        = 13,
  parameter int unsigned W          = 12,
  parameter int unsigned RADIX_BITS = 1,
  parameter int unsigned LANES      = 1,
  parameter int unsigned TAG_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_result,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned Q     = mo_q(Q_K, Q_M);
  localparam int unsigned Lat   = mo_lat(W, RADIX_BITS);
  localparam int unsigned NIter = Lat - 2;

  if (!mo_params_ok(Q_M, Q_K, W, RADIX_BITS)) begin : gen_param_err
    $error("mo_mul_pipe: illegal parameter set (RADIX_BITS, W, Q_M or Q out of range)");
  end

  // Per-lane state of one stage; b is shifted so its low digit is always the next one.
  typedef struct packed {
    logic [W:0]   s;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } lane_state_t;

  // Stage 0 is the input capture, stages 1..NIter hold iteration results.
  lane_state_t        st_q   [NIter+1][LANES];
  lane_state_t        st_d   [NIter+1][LANES];
  logic [TAG_W-1:0]   tag_q  [NIter+1];
  logic [NIter:0]     vld_q;
  logic [W:0]         iter_s [NIter][LANES];

  logic               out_valid_q;
  logic [LANES*W-1:0] out_result_q;
  logic [LANES*W-1:0] result_d;
  logic [TAG_W-1:0]   out_tag_q;
  logic               adv;

  assign adv        = !out_valid_q || out_ready;
  assign in_ready   = adv;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

  for (genvar k = 0; k < NIter; k++) begin : gen_stage
    for (genvar l = 0; l < LANES; l++) begin : gen_lane
      mo_mul_iter #(
        .W         (W),
        .RADIX_BITS(RADIX_BITS),
        .Q         (Q)
      ) u_iter (
        .s_i     (st_q[k][l].s),
        .a_i     (st_q[k][l].a),
        .d_i     (st_q[k][l].b[RADIX_BITS-1:0]),
        .s_next_o(iter_s[k][l])
      );
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      st_d[0][l].s = '0;
      st_d[0][l].a = in_a[l*W +: W];
      st_d[0][l].b = in_b[l*W +: W];
      for (int k = 1; k <= NIter; k++) begin
        st_d[k][l].s = iter_s[k-1][l];
        st_d[k][l].a = st_q[k-1][l].a;
        st_d[k][l].b = st_q[k-1][l].b >> RADIX_BITS;
      end
    end
  end

  // Final conditional subtraction; S < 2Q so one subtraction fully reduces.
  always_comb begin
    result_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (st_q[NIter][l].s >= (W+1)'(Q)) begin
        result_d[l*W +: W] = W'(st_q[NIter][l].s - (W+1)'(Q));
      end else begin
        result_d[l*W +: W] = W'(st_q[NIter][l].s);
      end
    end
  end

  // Datapath registers carry no reset; their validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (adv) begin
      st_q     <= st_d;
      tag_q[0] <= in_tag;
      for (int k = 1; k <= NIter; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (adv) begin
      vld_q        <= {vld_q[NIter-1:0], in_valid};
      out_valid_q  <= vld_q[NIter];
      out_result_q <= result_d;
      out_tag_q    <= tag_q[NIter];
    end
  end

endmodule
